// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO (read and write sides).
package fifo_pkg;

    // Default memory address width; FIFO depth is 2**ADDRSIZE_DEF.
    localparam int unsigned ADDRSIZE_DEF = 3;

    // Widest pointer the helpers handle; callers zero-extend into this word.
    localparam int unsigned PTR_MAXW = 32;

    typedef logic [PTR_MAXW-1:0] ptr_word_t;

    // Binary to reflected Gray code; width-agnostic for zero-extended input.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary over the low w bits: each binary bit is the XOR of the
    // Gray bits at and above its position.
    function automatic ptr_word_t gray2bin(input ptr_word_t g, input int unsigned w);
        ptr_word_t b;
        b = '0;
        for (int unsigned i = 0; i < PTR_MAXW; i++) begin
            if (i < w) begin
                b[i] = ^(g >> i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty.sv
// Read-side pointer, empty/almost-empty flags, occupancy and sticky
// underflow flag for the asynchronous FIFO. Everything runs on rclk.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE      = ADDRSIZE_DEF,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic                rerr_clr,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                rerr
);

    localparam int unsigned PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin;
    logic [PW-1:0] count_next;
    logic          pop;

    // Next-state pointer and occupancy; the full PW-bit pointers are used so
    // the MSB separates laps around the memory.
    always_comb begin
        pop        = rinc & ~rempty;
        rbinnext   = rbin + PW'(pop);
        rgraynext  = PW'(bin2gray(ptr_word_t'(rbinnext)));
        wbin       = PW'(gray2bin(ptr_word_t'(rq2_wptr), PW));
        count_next = wbin - rbinnext;
    end

    // Pointer registers; rptr comes straight from flops so it stays glitch-free Gray.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin <= '0;
            rptr <= '0;
        end else begin
            rbin <= rbinnext;
            rptr <= rgraynext;
        end
    end

    // Status flags and occupancy, all computed from the post-pop pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rcount  <= '0;
        end else begin
            rempty  <= (rgraynext == rq2_wptr);
            raempty <= (count_next <= AE_TH);
            rcount  <= count_next;
        end
    end

    // Sticky underflow flag; a new underflow takes priority over the clear.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rerr <= 1'b0;
        end else if (rinc && rempty) begin
            rerr <= 1'b1;
        end else if (rerr_clr) begin
            rerr <= 1'b0;
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: doc/rptr_empty.md
Name: rptr_empty

Overview:
- Read-domain pointer and empty-flag controller for the asynchronous FIFO.
- Sits directly downstream of the write-to-read pointer synchronizer and consumes its synchronized Gray write pointer.
- Produces the read memory address, the Gray read pointer (sent to the read-to-write synchronizer), and the empty, almost-empty, occupancy and underflow-error status.
- All logic runs in the rclk domain.

Parameters:
- ADDRSIZE, 3: memory address width. FIFO depth is 2^ADDRSIZE. Pointer width is ADDRSIZE+1.
- AEMPTY_THRESH, 2: raempty asserts when occupancy <= this value. Legal range is 0 to 2^ADDRSIZE-1.

Ports:
- rclk  in  1: read-domain clock.
- rrst_n  in  1: asynchronous, active-low reset.
- rinc  in  1: read request; the pop is accepted only when rempty=0.
- rerr_clr  in  1: clears the sticky underflow flag.
- rq2_wptr  in  ADDRSIZE+1: Gray write pointer, already synchronized into rclk.
- rptr  out  ADDRSIZE+1: registered Gray read pointer, to the read-to-write synchronizer.
- raddr  out  ADDRSIZE: read address to the dual-port memory. Equals the low bits of the binary read pointer.
- rempty  out  1: registered empty flag.
- raempty  out  1: registered almost-empty flag.
- rcount  out  ADDRSIZE+1: registered occupancy as seen from the read side, range 0 to 2^ADDRSIZE.
- rerr  out  1: sticky underflow flag.

Behaviour:
- Clocking and reset: one clock, rclk. Reset rrst_n is asynchronous and active-low.
- Reset values (applied immediately on rrst_n falling, no clock edge needed): rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rcount=0, rerr=0.
- Pop: pop = rinc & ~rempty. rbinnext = rbin + pop, modulo 2^(ADDRSIZE+1). rgraynext = (rbinnext>>1) ^ rbinnext.
- Pointer update: on each rclk edge, rbin<=rbinnext and rptr<=rgraynext. raddr = rbin[ADDRSIZE-1:0], taken directly from the register with no extra logic.
- Read data: memory data at raddr is the head entry. It is valid whenever rempty=0, and the consumer samples it in the same cycle as rinc.
- Empty: rempty <= (rgraynext == rq2_wptr).
  - Asserts on the same edge that pops the last entry, with zero-cycle latency.
  - Deasserts on the first rclk edge after rq2_wptr changes. This is pessimistic by design, because of the 2-cycle synchronizer upstream.
- Occupancy:
  - wbin = Gray-to-binary of rq2_wptr.
  - count_next = (wbin - rbinnext) mod 2^(ADDRSIZE+1).
  - rcount <= count_next. raempty <= (count_next <= AEMPTY_THRESH).
  - count_next > 2^ADDRSIZE cannot happen with a legal writer. No special handling is required, and the bench flags it as an error.
- Wrap-around: the pointer MSB distinguishes laps. Gray comparison of all ADDRSIZE+1 bits is required; comparing only the low bits is forbidden.
- Underflow: if rinc=1 and rempty=1, rerr sets on the next edge and the pointer does not move.
  - rerr clears when rerr_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous pop and rq2_wptr change: both enter count_next in the same cycle, and the flags reflect the combined result.
- Reset mid-operation: any in-flight pop is lost. All outputs return to their reset values asynchronously. Operation resumes on the first rclk edge after rrst_n deasserts.
- No combinational path from rinc to rptr. rptr must be glitch-free Gray, taken straight from flops.

Decomposition:
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized on pointer width;
  - the default ADDRSIZE constant.
- The upstream write-side pointer logic uses the same package.
- No sub-module: this is a single module, with Gray conversion done through the package functions.

Test Plan:
Defaults apply (ADDRSIZE=3, AEMPTY_THRESH=2).
1. Reset: hold rrst_n=0 with rinc=1 toggling -> rempty=1, raempty=1, rptr=0000, raddr=000, rcount=0, rerr=0, held throughout.
2. Fill and drain:
   - Set rq2_wptr=0010 (binary 3) with rinc=0 -> next edge: rempty=0, rcount=3, raempty=0.
   - Then rinc=1 for 3 cycles -> raddr steps 000, 001, 010.
   - After the 3rd edge: rptr=0010, rempty=1, rcount=0, raempty=1.
3. Underflow:
   - rinc=1 while empty -> rptr unchanged, rerr=1 next edge.
   - rinc=1 with rerr_clr=1 -> rerr stays 1.
   - rerr_clr=1 alone -> rerr=0.
4. Wrap: preset rbin=7 (rptr=0100) and rq2_wptr=1101 (binary 9), then pop twice -> rptr=1101, raddr=001, rempty=1, rcount=0. The bench compares full 4-bit Gray, not low bits.
5. Full and simultaneous:
   - rbin=0 with rq2_wptr=1100 (binary 8) -> rcount=8, rempty=0.
   - Separately, with rcount=1, pop and advance rq2_wptr by one in the same cycle -> rempty=0, rcount=1.
6. Async reset mid-drain: assert rrst_n between rclk edges while rcount=5 -> all outputs reach reset values before the next edge. After release, the first edge with rq2_wptr=0 keeps rempty=1.
